// File: rtl/z80_bus_master.sv
// Z80-style bus initiator: turns a REQ/ACK command into T-state-accurate memory,
// I/O and M1+refresh bus cycles, honouring WAIT_N and granting the bus on BUSRQ_N.
module z80_bus_master #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic        B_PHI,
  input  logic        RST,
  input  logic        REQ,
  input  logic [2:0]  REQ_TYPE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        BUSY,
  output logic        ACK,
  output logic        ERR,
  output logic [7:0]  RDATA,
  output logic [15:0] BA,
  output logic [7:0]  BD_OUT,
  output logic        BD_OE,
  input  logic [7:0]  BD_IN,
  output logic        BMREQ_N,
  output logic        IORQ_N,
  output logic        BRD_N,
  output logic        N_BWR,
  output logic        BM1_N,
  output logic        BRFSH_N,
  output logic        BUS_OE,
  input  logic        WAIT_N,
  input  logic        BUSRQ_N,
  output logic        BUSAK_N
);
  typedef enum logic [3:0] {
    S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4, S_DONE, S_BREL
  } state_t;

  localparam logic [2:0]  TY_MEMRD = 3'd0;
  localparam logic [2:0]  TY_MEMWR = 3'd1;
  localparam logic [2:0]  TY_IORD  = 3'd2;
  localparam logic [2:0]  TY_IOWR  = 3'd3;
  localparam logic [2:0]  TY_FETCH = 3'd4;
  localparam logic [1:0]  TWA_LAST = 2'(IO_AUTO_WAIT);
  localparam logic [15:0] TW_LIMIT = 16'(WAIT_TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [6:0]  r_q, r_d;
  logic [1:0]  twa_cnt_q, twa_cnt_d;
  logic [15:0] tw_cnt_q, tw_cnt_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] ba_q, ba_d;
  logic [7:0]  bd_out_q, bd_out_d;
  logic        bd_oe_q, bd_oe_d, busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  logic        mreq_n_q, mreq_n_d, iorq_n_q, iorq_n_d, rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d, m1_n_q, m1_n_d, rfsh_n_q, rfsh_n_d;
  logic        bus_oe_q, bus_oe_d, busak_n_q, busak_n_d;
  logic        sample_wait, go_t3;

  logic q_io, q_fetch, q_rd, d_mem, d_wr, d_fetch;
  assign q_io    = (type_q == TY_IORD) || (type_q == TY_IOWR);
  assign q_fetch = (type_q == TY_FETCH);
  assign q_rd    = (type_q == TY_MEMRD) || (type_q == TY_IORD);
  assign d_mem   = (type_d == TY_MEMRD) || (type_d == TY_MEMWR);
  assign d_wr    = (type_d == TY_MEMWR) || (type_d == TY_IOWR);
  assign d_fetch = (type_d == TY_FETCH);

  // Sequencing: next state, captured command, wait/timeout counters, read data.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    r_d         = r_q;
    twa_cnt_d   = twa_cnt_q;
    tw_cnt_d    = tw_cnt_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    sample_wait = 1'b0;
    go_t3       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!BUSRQ_N) begin
          state_d = S_BREL;
        end else if (REQ) begin
          type_d  = REQ_TYPE;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          tmo_d   = 1'b0;
          state_d = (REQ_TYPE > TY_FETCH) ? S_DONE : S_T1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        if (q_io && (IO_AUTO_WAIT > 0)) begin
          state_d   = S_TWA;
          twa_cnt_d = 2'd1;
        end else begin
          sample_wait = 1'b1;
        end
      end
      S_TWA: begin
        if (twa_cnt_q == TWA_LAST) sample_wait = 1'b1;
        else                       twa_cnt_d = twa_cnt_q + 2'd1;
      end
      S_TW: begin
        if (!WAIT_N && ((TW_LIMIT == 16'd0) || (tw_cnt_q != TW_LIMIT))) begin
          tw_cnt_d = tw_cnt_q + 16'd1;
        end else begin
          if (!WAIT_N) tmo_d = 1'b1;
          go_t3 = 1'b1;
        end
      end
      S_T3: begin
        if (q_rd) rdata_d = BD_IN;
        state_d = q_fetch ? S_T4 : S_DONE;
      end
      S_T4: begin
        r_d     = r_q + 7'd1;
        state_d = S_DONE;
      end
      S_BREL:  state_d = BUSRQ_N ? S_IDLE : S_BREL;
      default: state_d = S_IDLE;
    endcase
    if (sample_wait) begin
      if (!WAIT_N) begin
        state_d  = S_TW;
        tw_cnt_d = 16'd1;
      end else begin
        go_t3 = 1'b1;
      end
    end
    // The opcode is latched as the fetch leaves its read phase, before refresh.
    if (go_t3) begin
      state_d = S_T3;
      if (q_fetch) rdata_d = BD_IN;
    end
  end

  // Bus outputs are a function of the state being entered, so they register cleanly.
  always_comb begin
    ba_d      = ba_q;
    bd_out_d  = bd_out_q;
    bd_oe_d   = 1'b0;
    mreq_n_d  = 1'b1;
    iorq_n_d  = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    m1_n_d    = 1'b1;
    rfsh_n_d  = 1'b1;
    bus_oe_d  = 1'b1;
    busak_n_d = 1'b1;
    busy_d    = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    case (state_d)
      S_T1: begin
        busy_d = 1'b1;
        ba_d   = addr_d;
        m1_n_d = !d_fetch;
        if (d_wr) begin
          bd_out_d = wdata_d;
          bd_oe_d  = 1'b1;
        end
      end
      S_T2, S_TWA, S_TW, S_T3: begin
        busy_d = 1'b1;
        if (!d_fetch) begin
          mreq_n_d = !d_mem;
          iorq_n_d = d_mem;
          rd_n_d   = d_wr;
          wr_n_d   = !d_wr;
          bd_oe_d  = d_wr;
        end else if (state_d == S_T3) begin
          rfsh_n_d = 1'b0;
          mreq_n_d = 1'b0;
          ba_d     = {9'b0, r_q};
        end else begin
          m1_n_d   = 1'b0;
          mreq_n_d = 1'b0;
          rd_n_d   = 1'b0;
        end
      end
      S_T4: begin
        busy_d   = 1'b1;
        rfsh_n_d = 1'b0;
        mreq_n_d = 1'b0;
        ba_d     = {9'b0, r_q};
      end
      S_DONE: begin
        busy_d = 1'b1;
        ack_d  = 1'b1;
        err_d  = tmo_d || (type_d > TY_FETCH);
      end
      S_BREL: begin
        bus_oe_d  = 1'b0;
        busak_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values in any statement order.
  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      type_q    <= 3'd0;
      addr_q    <= 16'd0;
      wdata_q   <= 8'd0;
      r_q       <= 7'd0;
      twa_cnt_q <= 2'd0;
      tw_cnt_q  <= 16'd0;
      tmo_q     <= 1'b0;
      rdata_q   <= 8'd0;
      ba_q      <= 16'd0;
      bd_out_q  <= 8'd0;
      bd_oe_q   <= 1'b0;
      mreq_n_q  <= 1'b1;
      iorq_n_q  <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      m1_n_q    <= 1'b1;
      rfsh_n_q  <= 1'b1;
      bus_oe_q  <= 1'b1;
      busak_n_q <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      r_q       <= r_d;
      twa_cnt_q <= twa_cnt_d;
      tw_cnt_q  <= tw_cnt_d;
      tmo_q     <= tmo_d;
      rdata_q   <= rdata_d;
      ba_q      <= ba_d;
      bd_out_q  <= bd_out_d;
      bd_oe_q   <= bd_oe_d;
      mreq_n_q  <= mreq_n_d;
      iorq_n_q  <= iorq_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      m1_n_q    <= m1_n_d;
      rfsh_n_q  <= rfsh_n_d;
      bus_oe_q  <= bus_oe_d;
      busak_n_q <= busak_n_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign BUSY    = busy_q;
  assign ACK     = ack_q;
  assign ERR     = err_q;
  assign RDATA   = rdata_q;
  assign BA      = ba_q;
  assign BD_OUT  = bd_out_q;
  assign BD_OE   = bd_oe_q;
  assign BMREQ_N = mreq_n_q;
  assign IORQ_N  = iorq_n_q;
  assign BRD_N   = rd_n_q;
  assign N_BWR   = wr_n_q;
  assign BM1_N   = m1_n_q;
  assign BRFSH_N = rfsh_n_q;
  assign BUS_OE  = bus_oe_q;
  assign BUSAK_N = busak_n_q;
endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: each transaction's expected T-state timeline is built
// from the cycle rules (phase list per type, waits, timeout) and compared cycle by cycle.
module tb_z80_bus_master;
  localparam int IOAW = 1;
  localparam int WT   = 4;

  logic        B_PHI, RST, REQ, BUSY, ACK, ERR, BD_OE, WAIT_N, BUSRQ_N, BUSAK_N;
  logic        BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, BUS_OE;
  logic [2:0]  REQ_TYPE;
  logic [15:0] REQ_ADDR, BA;
  logic [7:0]  REQ_WDATA, RDATA, BD_OUT, BD_IN;

  z80_bus_master #(.IO_AUTO_WAIT(IOAW), .WAIT_TIMEOUT(WT)) dut (
    .B_PHI(B_PHI), .RST(RST), .REQ(REQ), .REQ_TYPE(REQ_TYPE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BA(BA),
    .BD_OUT(BD_OUT), .BD_OE(BD_OE), .BD_IN(BD_IN), .BMREQ_N(BMREQ_N), .IORQ_N(IORQ_N),
    .BRD_N(BRD_N), .N_BWR(N_BWR), .BM1_N(BM1_N), .BRFSH_N(BRFSH_N), .BUS_OE(BUS_OE),
    .WAIT_N(WAIT_N), .BUSRQ_N(BUSRQ_N), .BUSAK_N(BUSAK_N)
  );

  initial B_PHI = 1'b0;
  always #5 B_PHI = ~B_PHI;

  typedef enum {P_T1, P_T2, P_TWA, P_TW, P_T3, P_T4, P_DONE} phase_e;
  typedef struct packed {
    logic bus_oe, busak_n, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, bd_oe, busy, ack;
  } ctl_t;
  localparam ctl_t IDLE_CTL = 11'b11111111000;
  localparam ctl_t BREL_CTL = 11'b00111111000;

  int         checks_n = 0;
  int         errors_n = 0;
  logic [6:0] r_m      = 7'd0;
  logic [7:0] rdata_m  = 8'd0;

  function automatic ctl_t cur_ctl();
    cur_ctl = {BUS_OE, BUSAK_N, BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, BD_OE, BUSY, ACK};
  endfunction

  // Expected control outputs for one phase of a given command type.
  function automatic ctl_t exp_ctl(input phase_e p, input logic [2:0] t);
    ctl_t c;
    bit fetch, mem, wr;
    fetch = (t == 3'd4);
    mem   = (t <= 3'd1);
    wr    = (t == 3'd1) || (t == 3'd3);
    c      = IDLE_CTL;
    c.busy = 1'b1;
    case (p)
      P_T1: begin c.m1_n = !fetch; c.bd_oe = wr; end
      P_T2, P_TWA, P_TW, P_T3: begin
        if (fetch && p == P_T3) begin c.rfsh_n = 1'b0; c.mreq_n = 1'b0; end
        else if (fetch) begin c.m1_n = 1'b0; c.mreq_n = 1'b0; c.rd_n = 1'b0; end
        else begin
          if (mem) c.mreq_n = 1'b0; else c.iorq_n = 1'b0;
          if (wr) begin c.wr_n = 1'b0; c.bd_oe = 1'b1; end else c.rd_n = 1'b0;
        end
      end
      P_T4:    begin c.rfsh_n = 1'b0; c.mreq_n = 1'b0; end
      default: c.ack = 1'b1;
    endcase
    return c;
  endfunction

  task automatic check_ctl(input string tag, input int k, input ctl_t exp);
    ctl_t act;
    act = cur_ctl();
    checks_n++;
    if (act !== exp) begin
      errors_n++;
      $display("FAIL %s ctl cyc=%0d got=%b exp=%b", tag, k, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_ctl(tag, 0, IDLE_CTL);
    checks_n++;
    if ({BA, BD_OUT, RDATA, ERR} !== 33'd0) begin
      errors_n++;
      $display("FAIL %s data BA=%h BD_OUT=%h RDATA=%h ERR=%b exp all 0", tag, BA, BD_OUT, RDATA, ERR);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge B_PHI); #1;
    REQ = 1'b0;
    @(negedge B_PHI);
    check_ctl(tag, 0, IDLE_CTL);
  endtask

  // Starts at a negedge with the DUT in IDLE or DONE; returns at the negedge of the ACK cycle.
  // w = number of cycles WAIT_N is held low starting at the wait-sample cycle.
  task automatic run_txn(input string tag, input logic [2:0] t, input logic [15:0] a,
                         input logic [7:0] wd, input int w, input logic [7:0] rv,
                         input int busrq_k);
    phase_e      ph[$];
    int          s, cap, tw;
    bit          rsvd, fetch, io, rd, tmo;
    logic [15:0] ba_exp;
    ctl_t        exp;
    rsvd  = (t > 3'd4);
    fetch = (t == 3'd4);
    io    = (t == 3'd2) || (t == 3'd3);
    rd    = (t == 3'd0) || (t == 3'd2) || fetch;
    tw    = (w < WT) ? w : WT;
    tmo   = !rsvd && (w > WT);
    cap   = 0;
    if (rsvd) begin
      ph.push_back(P_DONE);
    end else begin
      ph.push_back(P_T1);
      ph.push_back(P_T2);
      if (io) repeat (IOAW) ph.push_back(P_TWA);
      repeat (tw) ph.push_back(P_TW);
      if (fetch) cap = ph.size();
      ph.push_back(P_T3);
      if (rd && !fetch) cap = ph.size();
      if (fetch) ph.push_back(P_T4);
      ph.push_back(P_DONE);
    end
    s = io ? 2 + IOAW : 2;
    if (rd && !rsvd) rdata_m = rv;
    REQ = 1'b1; REQ_TYPE = t; REQ_ADDR = a; REQ_WDATA = wd; WAIT_N = 1'b1; BD_IN = ~rv;
    for (int k = 1; k <= ph.size(); k++) begin
      @(posedge B_PHI); #1;
      REQ    = 1'b0;
      WAIT_N = !(k >= s && k < s + w);
      BD_IN  = (k == cap) ? rv : ~rv;
      if (busrq_k != 0 && k >= busrq_k) BUSRQ_N = 1'b0;
      @(negedge B_PHI);
      exp = exp_ctl(ph[k-1], t);
      check_ctl(tag, k, exp);
      if (!rsvd) begin
        ba_exp = (fetch && (ph[k-1] == P_T3 || ph[k-1] == P_T4 || ph[k-1] == P_DONE))
                 ? {9'b0, r_m} : a;
        checks_n++;
        if (BA !== ba_exp) begin
          errors_n++;
          $display("FAIL %s BA cyc=%0d got=%h exp=%h", tag, k, BA, ba_exp);
        end
      end
      if (exp.bd_oe) begin
        checks_n++;
        if (BD_OUT !== wd) begin
          errors_n++;
          $display("FAIL %s BD_OUT cyc=%0d got=%h exp=%h", tag, k, BD_OUT, wd);
        end
      end
      if (fetch) begin
        checks_n++;
        if (!BM1_N && !BRFSH_N) begin
          errors_n++;
          $display("FAIL %s m1_rfsh_overlap cyc=%0d got=both_low exp=exclusive", tag, k);
        end
      end
    end
    checks_n++;
    if (ERR !== (rsvd || tmo) || RDATA !== rdata_m) begin
      errors_n++;
      $display("FAIL %s ack_data ERR=%b RDATA=%h exp ERR=%b RDATA=%h",
               tag, ERR, RDATA, rsvd || tmo, rdata_m);
    end
    if (fetch) r_m = r_m + 7'd1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 1'b0; REQ_TYPE = 3'd0; REQ_ADDR = 16'd0; REQ_WDATA = 8'd0;
    BD_IN = 8'd0; WAIT_N = 1'b1; BUSRQ_N = 1'b1;
    repeat (2) @(negedge B_PHI);
    check_reset_vals("reset");
    RST = 1'b0;
    idle_cycle("post_reset");
  endtask

  task automatic test_memrd();
    run_txn("memrd", 3'd0, 16'h2000, 8'h00, 0, 8'hA5, 0);
    idle_cycle("memrd_idle");
  endtask

  task automatic test_memwr_wait();
    run_txn("memwr_wait", 3'd1, 16'h8001, 8'h3C, 3, 8'h00, 0);
    idle_cycle("memwr_idle");
  endtask

  task automatic test_iord();
    run_txn("iord", 3'd2, 16'h0040, 8'h00, 0, 8'h5E, 0);
    idle_cycle("iord_idle");
  endtask

  task automatic test_fetch_refresh();
    for (int i = 0; i < 129; i++)
      run_txn("fetch", 3'd4, 16'($urandom), 8'h00, 0, 8'($urandom), 0);
    idle_cycle("fetch_idle");
  endtask

  task automatic test_busrq();
    run_txn("busrq_rd", 3'd0, 16'h1234, 8'h00, 0, 8'h77, 2);
    REQ = 1'b1; REQ_TYPE = 3'd0; REQ_ADDR = 16'h4321;
    for (int k = 0; k < 3; k++) begin
      @(posedge B_PHI); #1;
      @(negedge B_PHI);
      check_ctl("busrq_brel", k, BREL_CTL);
    end
    @(posedge B_PHI); #1;
    BUSRQ_N = 1'b1;
    @(negedge B_PHI);
    check_ctl("busrq_release", 0, BREL_CTL);
    @(posedge B_PHI); #1;
    @(negedge B_PHI);
    check_ctl("busrq_idle", 0, IDLE_CTL);
    run_txn("busrq_pending", 3'd0, 16'h4321, 8'h00, 0, 8'hC3, 0);
    idle_cycle("busrq_done_idle");
  endtask

  task automatic test_timeout();
    run_txn("tmo_memrd", 3'd0, 16'h0F0F, 8'h00, 99, 8'h96, 0);
    run_txn("tmo_iowr", 3'd3, 16'h00FE, 8'h5A, 99, 8'h00, 0);
    run_txn("wait_exact", 3'd0, 16'h0100, 8'h00, 4, 8'h21, 0);
    idle_cycle("tmo_idle");
  endtask

  task automatic test_rst_mid();
    REQ = 1'b1; REQ_TYPE = 3'd1; REQ_ADDR = 16'h5555; REQ_WDATA = 8'h99; WAIT_N = 1'b1;
    @(posedge B_PHI); #1;
    REQ = 1'b0; WAIT_N = 1'b0;
    repeat (3) @(posedge B_PHI);
    @(negedge B_PHI);
    checks_n++;
    if (N_BWR !== 1'b0 || BD_OE !== 1'b1 || ACK !== 1'b0) begin
      errors_n++;
      $display("FAIL rst_mid pre N_BWR=%b BD_OE=%b ACK=%b exp 0 1 0", N_BWR, BD_OE, ACK);
    end
    #1 RST = 1'b1;
    #1 check_reset_vals("rst_mid_now");
    @(posedge B_PHI); #1;
    RST = 1'b0; WAIT_N = 1'b1;
    r_m = 7'd0; rdata_m = 8'd0;
    for (int k = 0; k < 3; k++) idle_cycle("rst_mid_no_ack");
    run_txn("rst_fetch", 3'd4, 16'h0ABC, 8'h00, 0, 8'hE1, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] t;
    int         w;
    for (int i = 0; i < 40; i++) begin
      t = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
      if ($urandom_range(0, 1) == 0) idle_cycle("rand_gap");
      run_txn("rand", t, 16'($urandom), 8'($urandom), w, 8'($urandom), 0);
    end
    idle_cycle("rand_end");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_memrd();
    test_memwr_wait();
    test_iord();
    test_fetch_refresh();
    test_busrq();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end
endmodule
